// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, baud-period helpers and widths.
// Used by both the receive and transmit paths.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int baud_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  function automatic int half_cnt(input int clk_freq, input int bps);
    return baud_cnt(clk_freq, bps) / 2;
  endfunction
endpackage

// File: rtl/uart_rx_word_if.sv
// Word-level receive bundle: assembled word, its strobe, error pulses and busy.
interface uart_rx_word_if;
  import uart_pkg::*;
  logic [WORD_W-1:0] data;
  logic              data_valid;
  logic              frame_err;
  logic              timeout_err;
  logic              busy;

  modport master (output data, data_valid, frame_err, timeout_err, busy);
  modport slave  (input  data, data_valid, frame_err, timeout_err, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// Byte receiver: 2-FF sync + history flop, mid-bit sampling FSM, framing check.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 60000000,
  parameter int UART_BPS = 115200
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              uart_rxd,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              byte_err,
  output logic              busy,
  output logic              idle
);
  localparam int BAUD = baud_cnt(CLK_FREQ, UART_BPS);
  localparam int HALF = half_cnt(CLK_FREQ, UART_BPS);
  localparam int CW   = $clog2(BAUD + 1);

  logic              s1, s2, prev;
  logic [1:0]        settle;
  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic              fall, tick_half, tick_full, stop_hit, good;

  // Edges are ignored until the sync chain holds real line samples, so a
  // line already low when reset releases is not taken as a start bit.
  assign fall      = (settle == 2'd3) && prev && !s2;
  assign tick_half = (cnt == CW'(HALF - 1));
  assign tick_full = (cnt == CW'(BAUD - 1));
  assign stop_hit  = (state == ST_STOP) && tick_full;
  assign rx_byte   = shreg;
  assign idle      = (state == ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_ok;
  assign good = s2 && par_ok;
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                              par_ok <= 1'b1;
    else if (state == ST_PARITY && tick_full) par_ok <= ~^{shreg, s2};
  end
`else
  assign good = s2;
`endif

  assign byte_valid = stop_hit && good;
  assign byte_err   = stop_hit && !good;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      prev    <= 1'b1;
      settle  <= 2'd0;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= '0;
      busy    <= 1'b0;
    end else begin
      s1   <= uart_rxd;
      s2   <= s1;
      prev <= s2;
      if (settle != 2'd3) settle <= settle + 2'd1;
      cnt <= cnt + CW'(1);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fall) state <= ST_START;
        end
        ST_START: if (tick_half) begin
          cnt <= '0;
          if (!s2) begin
            state   <= ST_DATA;
            busy    <= 1'b1;
            bit_idx <= 3'd0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: if (tick_full) begin
          cnt     <= '0;
          shreg   <= {s2, shreg[BYTE_W-1:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= ST_PARITY;
`else
          if (bit_idx == 3'd7) state <= ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (tick_full) begin
          cnt   <= '0;
          state <= ST_STOP;
        end
`endif
        ST_STOP: if (tick_full) begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: pairs bytes MSB-first into 16-bit words and drops a
// lone high byte after TIMEOUT_BITS idle bit periods.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 60000000,
  parameter int UART_BPS     = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           uart_rxd,
  uart_rx_word_if.master rx
);
  localparam int BAUD   = baud_cnt(CLK_FREQ, UART_BPS);
  localparam int TO_CYC = TIMEOUT_BITS * BAUD;
  localparam int TW     = $clog2(TO_CYC + 1);

  logic [BYTE_W-1:0] rx_byte, hi;
  logic              byte_valid, byte_err, idle, have_hi;
  logic [TW-1:0]     idle_cnt;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) u_byte (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .busy      (rx.busy),
    .idle      (idle)
  );

  // Byte events only occur at the stop sample, never while idle, so the
  // timeout branch and the byte branch cannot collide.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx.data        <= '0;
      rx.data_valid  <= 1'b0;
      rx.frame_err   <= 1'b0;
      rx.timeout_err <= 1'b0;
      have_hi        <= 1'b0;
      hi             <= '0;
      idle_cnt       <= '0;
    end else begin
      rx.data_valid  <= 1'b0;
      rx.frame_err   <= 1'b0;
      rx.timeout_err <= 1'b0;
      if (have_hi && idle) begin
        if (idle_cnt == TW'(TO_CYC - 1)) begin
          idle_cnt       <= '0;
          have_hi        <= 1'b0;
          rx.timeout_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
      if (byte_err) begin
        rx.frame_err <= 1'b1;
        have_hi      <= 1'b0;
      end else if (byte_valid) begin
        if (have_hi) begin
          rx.data       <= {hi, rx_byte};
          rx.data_valid <= 1'b1;
          have_hi       <= 1'b0;
        end else begin
          hi      <= rx_byte;
          have_hi <= 1'b1;
        end
      end
    end
  end
endmodule
